// File: rtl/b10_serial_counter.sv
// Serial BCD up-counter: an increment ripples through the digits one per cycle
// using a single shared base-10 half-adder, terminating early once the carry dies.
module b10_serial_counter #(
  parameter int N_DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  start,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_value,
  output logic [4*N_DIGITS-1:0] value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int W = 4 * N_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] value_nxt;
  logic [2:0]   idx, idx_nxt;
  logic         carry, carry_nxt;
  logic         ovf_nxt;
  logic [3:0]   cur_digit;
  logic [3:0]   sum;
  logic         cout;
  logic         last_digit;

  function automatic logic [4:0] bcd_half_add(input logic [3:0] d, input logic c);
    logic [4:0] t;
    t = {1'b0, d} + {4'b0000, c};
    if (t > 5'd9) return {1'b1, t[3:0] - 4'd10};
    return t;
  endfunction

  // Non-decimal nibbles (A..F) are forced to zero on load.
  function automatic logic [W-1:0] bcd_sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < N_DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    return r;
  endfunction

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < N_DIGITS; i++)
      if (idx == 3'(i)) cur_digit = value[4*i +: 4];
  end

  assign {cout, sum} = bcd_half_add(cur_digit, carry);
  assign last_digit  = (idx == 3'(N_DIGITS - 1));

  always_comb begin
    state_nxt = state;
    value_nxt = value;
    idx_nxt   = idx;
    carry_nxt = carry;
    ovf_nxt   = overflow;
    unique case (state)
      IDLE: begin
        if (load) begin
          value_nxt = bcd_sanitize(load_value);
          ovf_nxt   = 1'b0;
        end else if (start) begin
          idx_nxt   = 3'd0;
          carry_nxt = 1'b1;
          ovf_nxt   = 1'b0;
          state_nxt = STEP;
        end
      end
      STEP: begin
        for (int i = 0; i < N_DIGITS; i++)
          if (idx == 3'(i)) value_nxt[4*i +: 4] = sum;
        carry_nxt = cout;
        idx_nxt   = idx + 3'd1;
        if (!cout || last_digit) begin
          state_nxt = DONE;
          if (cout) ovf_nxt = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      value    <= '0;
      idx      <= 3'd0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      value    <= value_nxt;
      idx      <= idx_nxt;
      carry    <= carry_nxt;
      overflow <= ovf_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_b10_serial_counter.sv
// Directed plus randomized bench for b10_serial_counter, checked against an
// integer-arithmetic model of the BCD count.
module tb_b10_serial_counter;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clock;
  logic         reset_;
  logic         start;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] value;
  logic         busy;
  logic         done;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  int model_val = 0;
  int model_ovf = 0;

  b10_serial_counter #(.N_DIGITS(N)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .start     (start),
    .load      (load),
    .load_value(load_value),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal meaning of a raw load word, with invalid nibbles read as 0.
  function automatic int load2int(input logic [W-1:0] v);
    int s = 0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 0;
      s = s + d * pow10(i);
    end
    return s;
  endfunction

  task automatic do_load(input logic [W-1:0] v, input logic with_start);
    load_value = v;
    load       = 1'b1;
    start      = with_start;
    tick();
    load  = 1'b0;
    start = 1'b0;
    model_val = load2int(v);
    model_ovf = 0;
    chk("load_value", 32'(value), 32'(int2bcd(model_val)));
    chk("load_busy", 32'(busy), 32'd0);
    chk("load_ovf", 32'(overflow), 32'd0);
    if (with_start) begin
      tick();
      chk("ld_st_busy", 32'(busy), 32'd0);
      chk("ld_st_value", 32'(value), 32'(int2bcd(model_val)));
    end
  endtask

  // noise: 0 quiet, 1 random start/load while busy, 2 load 1234 + start while busy
  task automatic run_inc(input int noise);
    int k, steps, cnt, tmp, exp_val, exp_ovf;
    tmp = model_val;
    k = 0;
    while (k < N && tmp % 10 == 9) begin
      k++;
      tmp = tmp / 10;
    end
    steps   = (k < N) ? k + 1 : N;
    exp_ovf = (k == N) ? 1 : 0;
    exp_val = (model_val + 1) % pow10(N);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("inc_busy0", 32'(busy), 32'd1);
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      if (noise == 1) begin
        start      = 1'($urandom_range(1));
        load       = 1'($urandom_range(1));
        load_value = W'($urandom);
      end else if (noise == 2) begin
        start      = 1'b1;
        load       = 1'b1;
        load_value = 16'h1234;
      end
      tick();
      cnt++;
    end
    start = 1'b0;
    load  = 1'b0;
    chk("inc_latency", 32'(cnt), 32'(steps));
    chk("inc_value", 32'(value), 32'(int2bcd(exp_val)));
    chk("inc_ovf", 32'(overflow), 32'(exp_ovf));
    chk("inc_busy_done", 32'(busy), 32'd1);
    tick();
    chk("inc_done_width", 32'(done), 32'd0);
    chk("inc_idle", 32'(busy), 32'd0);
    chk("inc_hold", 32'(value), 32'(int2bcd(exp_val)));
    chk("inc_ovf_hold", 32'(overflow), 32'(exp_ovf));
    model_val = exp_val;
    model_ovf = exp_ovf;
  endtask

  initial begin
    reset_     = 1'b1;
    start      = 1'b0;
    load       = 1'b0;
    load_value = '0;
    #1 reset_ = 1'b0;
    #1;
    chk("rst_async_value", 32'(value), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_done", 32'(done), 32'd0);
    chk("rst_async_ovf", 32'(overflow), 32'd0);
    tick();
    tick();
    reset_ = 1'b1;
    tick();
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    model_val = 0;

    run_inc(0);                       // 0000 -> 0001
    do_load(16'h0199, 1'b0);
    run_inc(0);                       // 0199 -> 0200
    do_load(16'h9999, 1'b0);
    run_inc(0);                       // wrap, overflow
    do_load(16'h0005, 1'b0);
    do_load(16'h0899, 1'b0);
    run_inc(1);                       // random start/load ignored while busy
    do_load(16'h0999, 1'b0);
    run_inc(2);                       // load 1234 ignored while busy
    do_load(16'h12A4, 1'b0);          // -> 1204
    do_load(16'h4321, 1'b1);          // load beats start

    // Reset in the second STEP cycle aborts with no done pulse.
    do_load(16'h0999, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset_ = 1'b0;
    #1;
    chk("abort_value", 32'(value), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    reset_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_nodone", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    model_val = 0;
    model_ovf = 0;
    run_inc(0);                       // -> 0001

    for (int it = 0; it < 40; it++) begin
      logic [W-1:0] lv;
      int nines;
      lv = W'($urandom);
      if (it % 4 != 0) begin
        lv = int2bcd(int'($urandom_range(pow10(N) - 1)));
        nines = int'($urandom_range(N));
        for (int d = 0; d < nines; d++) lv[4*d +: 4] = 4'd9;
      end
      do_load(lv, 1'($urandom_range(1) & (it % 5 == 0)));
      run_inc(int'($urandom_range(1)));
      if (it % 7 == 0) run_inc(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
